// File: rtl/riscv_fetch_ctrl.sv
// Instruction fetch controller: drives the ROM address, captures words into a
// single-entry valid/ready slot toward decode and reports fetch faults.
module riscv_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  output logic [63:0] mem_address_o,
  input  logic [31:0] mem_instruction_i,
  input  logic        mem_error_misaligned_i,
  input  logic        mem_error_invalid_address_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [63:0] fault_pc_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;

  logic accept;
  logic slot_free;
  logic rom_err;
  logic run_stop;
  logic run_hold;
  logic run_fault;
  logic run_fetch;

  assign mem_address_o = pc_q;

  assign accept    = valid_o & ready_i;
  assign slot_free = ~valid_o | ready_i;
  assign rom_err   = mem_error_misaligned_i
                   | mem_error_invalid_address_i;

  // ROM errors only matter when a word could actually be taken.
  assign run_stop  = ~enable_i;
  assign run_hold  = enable_i & ~slot_free;
  assign run_fault = enable_i & slot_free & rom_err;
  assign run_fetch = enable_i & slot_free & ~rom_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_o       <= '0;
      pc_o          <= '0;
      valid_o       <= 1'b0;
      fault_o       <= 1'b0;
      fault_cause_o <= '0;
      fault_pc_o    <= '0;
      fetch_count_o <= '0;
    end else begin
      // A handshake always retires, even alongside a redirect.
      if (accept) begin
        fetch_count_o <= fetch_count_o + 32'd1;
        valid_o       <= 1'b0;
      end

      if (redirect_i) begin
        pc_q          <= redirect_pc_i;
        valid_o       <= 1'b0;
        fault_o       <= 1'b0;
        fault_cause_o <= '0;
        state_q       <= enable_i ? RUN : IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (enable_i) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            unique case (1'b1)
              run_stop: begin
                state_q <= IDLE;
              end
              run_hold: begin
                state_q <= RUN;
              end
              run_fault: begin
                state_q       <= FAULT;
                fault_o       <= 1'b1;
                fault_pc_o    <= pc_q;
                fault_cause_o <= {mem_error_invalid_address_i,
                                  mem_error_misaligned_i};
              end
              run_fetch: begin
                instr_o <= mem_instruction_i;
                pc_o    <= pc_q;
                valid_o <= 1'b1;
                pc_q    <= pc_q + 64'd4;
              end
              default: begin
                state_q <= RUN;
              end
            endcase
          end
          FAULT: begin
            state_q <= FAULT;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Bench for riscv_fetch_ctrl: directed scenarios plus random traffic,
// compared every cycle against a cycle-level behavioural model.
module tb_riscv_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] TOP_BASE = 64'hFFFF_FFFF_FFFF_FF00;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] mem_address;
  logic [31:0] mem_instruction;
  logic        mem_mis;
  logic        mem_inv;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        valid;
  logic        ready;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  riscv_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk_i                       (clk),
    .rst_ni                      (rst_n),
    .enable_i                    (enable),
    .mem_address_o               (mem_address),
    .mem_instruction_i           (mem_instruction),
    .mem_error_misaligned_i      (mem_mis),
    .mem_error_invalid_address_i (mem_inv),
    .redirect_i                  (redirect),
    .redirect_pc_i               (redirect_pc),
    .instr_o                     (instr),
    .pc_o                        (pc),
    .valid_o                     (valid),
    .ready_i                     (ready),
    .fault_o                     (fault),
    .fault_cause_o               (fault_cause),
    .fault_pc_o                  (fault_pc),
    .fetch_count_o               (fetch_count)
  );

  always #5 clk = ~clk;

  // ROM: 512 bytes at 0 and 256 bytes just below 2^64.
  function automatic bit rom_invalid(logic [63:0] a);
    return !((a < 64'h200) || (a >= TOP_BASE));
  endfunction

  function automatic logic [31:0] rom_word(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  always_comb begin
    mem_instruction = rom_word(mem_address);
    mem_mis         = (mem_address[1:0] != 2'b00);
    mem_inv         = rom_invalid(mem_address);
  end

  // Behavioural model state.
  int          m_mode;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_pcout;
  bit          m_valid;
  bit          m_fault;
  logic [1:0]  m_cause;
  logic [63:0] m_fpc;
  logic [31:0] m_count;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = RESET_PC;
    m_instr = '0;
    m_pcout = '0;
    m_valid = 0;
    m_fault = 0;
    m_cause = '0;
    m_fpc   = '0;
    m_count = '0;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("mem_address", mem_address, m_pc);
    chk("valid", 64'(valid), 64'(m_valid));
    chk("instr", 64'(instr), 64'(m_instr));
    chk("pc_o", pc, m_pcout);
    chk("fault", 64'(fault), 64'(m_fault));
    chk("fault_cause", 64'(fault_cause), 64'(m_cause));
    chk("fault_pc", fault_pc, m_fpc);
    chk("fetch_count", 64'(fetch_count), 64'(m_count));
  endtask

  // One clock: model next state from current inputs, advance, compare.
  task automatic cycle();
    int          n_mode  = m_mode;
    logic [63:0] n_pc    = m_pc;
    logic [31:0] n_instr = m_instr;
    logic [63:0] n_pcout = m_pcout;
    bit          n_valid = m_valid && !ready;
    bit          n_fault = m_fault;
    logic [1:0]  n_cause = m_cause;
    logic [63:0] n_fpc   = m_fpc;
    logic [31:0] n_count = m_count;
    bit          mis;
    bit          inv;
    if (m_valid && ready) n_count = m_count + 1;
    if (redirect) begin
      n_pc    = redirect_pc;
      n_valid = 0;
      n_fault = 0;
      n_cause = 2'b00;
      n_mode  = enable ? M_RUN : M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (enable) n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!enable) begin
        n_mode = M_IDLE;
      end else if (!m_valid || ready) begin
        mis = (m_pc % 4) != 0;
        inv = rom_invalid(m_pc);
        if (mis || inv) begin
          n_mode  = M_FAULT;
          n_fault = 1;
          n_fpc   = m_pc;
          n_cause = inv ? (mis ? 2'b11 : 2'b10) : 2'b01;
        end else begin
          n_instr = rom_word(m_pc);
          n_pcout = m_pc;
          n_valid = 1;
          n_pc    = m_pc + 64'd4;
        end
      end
    end
    @(posedge clk);
    m_mode  = n_mode;
    m_pc    = n_pc;
    m_instr = n_instr;
    m_pcout = n_pcout;
    m_valid = n_valid;
    m_fault = n_fault;
    m_cause = n_cause;
    m_fpc   = n_fpc;
    m_count = n_count;
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(bit en, bit rdy, bit rd, logic [63:0] rpc);
    enable      = en;
    ready       = rdy;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  // Asynchronous reset pulse applied away from the clock edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    chk("rst_count", 64'(fetch_count), 64'h0);
    chk("rst_addr", mem_address, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    case ($urandom_range(0, 5))
      0, 1:    t = 64'($urandom_range(0, 127)) * 64'd4;
      2:       t = 64'($urandom_range(0, 511));
      3:       t = 64'h1F0 + 64'($urandom_range(0, 8)) * 64'd4;
      4:       t = TOP_BASE + 64'($urandom_range(0, 63)) * 64'd4;
      default: t = {$urandom, $urandom};
    endcase
    return t;
  endfunction

  logic [31:0] saved_count;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, '0);
    model_reset();
    @(negedge clk);
    compare_all();
    chk("init_valid", 64'(valid), 64'h0);
    chk("init_pc", pc, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line fetch of 0x0, 0x4, 0x8.
    drive(1, 1, 0, '0);
    cycle();
    chk("first_no_valid", 64'(valid), 64'h0);
    cycle();
    chk("f0_pc", pc, 64'h0);
    chk("f0_instr", 64'(instr), 64'(rom_word(64'h0)));
    cycle();
    chk("f1_pc", pc, 64'h4);
    cycle();
    chk("f2_pc", pc, 64'h8);
    drive(0, 1, 0, '0);
    cycle();
    chk("count3", 64'(fetch_count), 64'd3);
    chk("idle_no_valid", 64'(valid), 64'h0);

    // Backpressure for four cycles at pc_o=0x4.
    drive(1, 1, 1, 64'h0);
    cycle();
    drive(1, 1, 0, '0);
    cycle();
    cycle();
    chk("bp_start", pc, 64'h4);
    drive(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_pc", pc, 64'h4);
      chk("bp_valid", 64'(valid), 64'h1);
      chk("bp_addr", mem_address, 64'h8);
    end
    drive(1, 1, 0, '0);
    cycle();
    chk("bp_next", pc, 64'h8);

    // Redirect while stalled discards the pending word.
    saved_count = fetch_count;
    drive(1, 0, 1, 64'h40);
    cycle();
    chk("rd_valid", 64'(valid), 64'h0);
    chk("rd_addr", mem_address, 64'h40);
    chk("rd_count", 64'(fetch_count), 64'(saved_count));
    drive(1, 1, 0, '0);
    cycle();
    chk("rd_pc", pc, 64'h40);

    // Misaligned target faults, then recovers.
    drive(1, 1, 1, 64'h42);
    cycle();
    drive(1, 1, 0, '0);
    cycle();
    chk("mis_fault", 64'(fault), 64'h1);
    chk("mis_cause", 64'(fault_cause), 64'h1);
    chk("mis_fpc", fault_pc, 64'h42);
    chk("mis_valid", 64'(valid), 64'h0);
    cycle();
    chk("fault_sticky", 64'(fault), 64'h1);
    drive(1, 1, 1, 64'h100);
    cycle();
    chk("clr_fault", 64'(fault), 64'h0);
    drive(1, 1, 0, '0);
    cycle();
    chk("resume_pc", pc, 64'h100);

    // Run off the end of the low ROM region.
    drive(1, 1, 1, 64'h1F8);
    cycle();
    drive(1, 1, 0, '0);
    cycle();
    cycle();
    chk("edge_pc", pc, 64'h1FC);
    cycle();
    chk("inv_fault", 64'(fault), 64'h1);
    chk("inv_cause", 64'(fault_cause), 64'h2);
    chk("inv_fpc", fault_pc, 64'h200);
    reset_pulse();
    drive(1, 1, 0, '0);
    cycle();
    cycle();
    chk("restart_pc", pc, RESET_PC);
    chk("restart_valid", 64'(valid), 64'h1);

    // Program counter wrap at 2^64.
    drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    cycle();
    drive(1, 1, 0, '0);
    cycle();
    cycle();
    chk("wrap_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", mem_address, 64'h0);
    cycle();
    chk("wrap_pc", pc, 64'h0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse();
      end else begin
        drive($urandom_range(0, 9) != 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0,
              rand_target());
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_ctrl.md
RISCV_FETCH_CTRL -- requirements
Module: riscv_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, 64'h0, program counter value loaded on reset.
REQ-002 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port enable_i  input  1  fetch permission from core control.
REQ-005 The block SHALL have port mem_address_o  output  64  address driven to the instruction memory ROM.
REQ-006 The block SHALL have port mem_instruction_i  input  32  combinational ROM read data.
REQ-007 The block SHALL have ports mem_error_misaligned_i and mem_error_invalid_address_i  input  1 each  combinational ROM error flags.
REQ-008 The block SHALL have ports redirect_i (input, 1) and redirect_pc_i (input, 64)  branch/jump/trap target request.
REQ-009 The block SHALL have ports instr_o (output, 32), pc_o (output, 64), valid_o (output, 1), ready_i (input, 1)  valid/ready handshake to decode.
REQ-010 The block SHALL have ports fault_o (output, 1), fault_cause_o (output, 2), fault_pc_o (output, 64)  fetch fault report.
REQ-011 The block SHALL have port fetch_count_o  output  32  count of accepted instructions.

Function
REQ-012 The block SHALL hold a 64-bit pc_q and drive mem_address_o = pc_q combinationally.
REQ-013 The block SHALL implement states IDLE, RUN, FAULT; reset state IDLE.
REQ-014 IDLE -> RUN when enable_i=1; RUN -> IDLE when enable_i=0 (no capture in that cycle); FAULT exits only via redirect_i.
REQ-015 Output slot is "free" when valid_o=0 or (valid_o=1 and ready_i=1).
REQ-016 In RUN with slot free, enable_i=1, no redirect and both ROM error flags 0: capture instr_o<=mem_instruction_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4; latency one cycle from address to valid_o.
REQ-017 pc_q+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-018 In RUN with slot free and any ROM error flag 1: no capture, pc_q unchanged, state -> FAULT, fault_o<=1, fault_pc_o<=pc_q, fault_cause_o<={invalid,misaligned} (2'b01 misaligned, 2'b10 invalid, 2'b11 both).
REQ-019 With slot not free (valid_o=1, ready_i=0): instr_o, pc_o, valid_o, pc_q SHALL hold; errors not sampled.
REQ-020 In FAULT, a pending valid_o SHALL remain until accepted, then valid_o<=0; no new fetches.
REQ-021 redirect_i=1 has highest priority in any state: pc_q<=redirect_pc_i, valid_o<=0 (pending instruction discarded, not counted), fault_o<=0, fault_cause_o<=0; next state RUN if enable_i=1 else IDLE.
REQ-022 Redirect and handshake in the same cycle: handshake counts as accepted (fetch_count_o increments), redirect still applied.
REQ-023 fetch_count_o SHALL increment by 1 on each cycle with valid_o=1 and ready_i=1, wrapping 32'hFFFF_FFFF -> 0.
REQ-024 Redirect to misaligned or out-of-range target SHALL be accepted; fault raised on next fetch attempt per REQ-018.
REQ-025 No combinational path from ready_i or redirect_i to any output.

Reset
REQ-026 On rst_ni=0, asynchronously: state IDLE, pc_q=RESET_PC, instr_o=0, pc_o=0, valid_o=0, fault_o=0, fault_cause_o=0, fault_pc_o=0, fetch_count_o=0.
REQ-027 Reset asserted mid-operation SHALL discard any pending instruction and fault; first fetch after release at RESET_PC once enable_i=1.

Verification
REQ-028 Reset release, enable_i=1, ready_i=1, ROM holds words at 0x0,0x4,0x8 -> valid_o high from 2nd cycle, pc_o 0x0,0x4,0x8 consecutively, fetch_count_o=3.
REQ-029 ready_i=0 for 4 cycles with valid_o=1 at pc_o=0x4 -> outputs and mem_address_o=0x8 stable 4 cycles; ready_i=1 -> next pc_o=0x8, no skipped/duplicated instruction.
REQ-030 redirect_i=1, redirect_pc_i=0x40 while valid_o=1, ready_i=0 -> next cycle valid_o=0, mem_address_o=0x40; following pc_o=0x40, count unchanged.
REQ-031 redirect_pc_i=0x42 -> fault_o=1, fault_cause_o=2'b01, fault_pc_o=0x42, valid_o=0; redirect to 0x100 clears fault and resumes.
REQ-032 Fetch reaches first out-of-range address -> fault_cause_o=2'b10; rst_ni pulsed low mid-fault -> all outputs zero, restart at RESET_PC.
